// File: rtl/sample_byte_serializer_pkg.sv
// Shared definitions for the sample-to-byte serializer: FSM state encoding
// and sample geometry.
package sample_byte_serializer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_SEND  = 2'd2;

  localparam int Q_IN = 32;

  function automatic int bytes_per_sample(input int q_in);
    return q_in / 8;
  endfunction

  localparam int BYTES_PER_SAMPLE = bytes_per_sample(Q_IN);

endpackage

// File: rtl/sample_fifo_circular.sv
// Circular sample buffer with accept/drop decision and a sticky overflow flag.
// A push into a full buffer still succeeds when a pop happens in the same cycle.
module sample_fifo_circular #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  data_o,
  output logic [ADDR_W:0]   fill_level_o,
  output logic              overflow_o,
  input  logic              clear_overflow_i
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   fill_q, fill_d;
  logic              overflow_q, overflow_d;
  logic              accept_s;

  // Pointer, fill-level and overflow next-state; a drop outranks a clear.
  always_comb begin
    accept_s = push_i && ((fill_q != FULL_LEVEL) || pop_i);
    wr_ptr_d = accept_s ? (wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop_i ? (rd_ptr_q + 1'b1) : rd_ptr_q;
    case ({accept_s, pop_i})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
    if (push_i && !accept_s) begin
      overflow_d = 1'b1;
    end else if (clear_overflow_i) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= {ADDR_W{1'b0}};
      rd_ptr_q   <= {ADDR_W{1'b0}};
      fill_q     <= {(ADDR_W+1){1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
    end
  end

  // Sample storage; contents survive reset.
  always_ff @(posedge clock) begin
    if (accept_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o       = mem_q[rd_ptr_q];
  assign fill_level_o = fill_q;
  assign overflow_o   = overflow_q;

endmodule

// File: rtl/sample_byte_serializer.sv
// Buffers signed samples and emits each one MSB-first as bytes on a
// valid/ready interface, with one bubble cycle between samples.
module sample_byte_serializer
  import sample_byte_serializer_pkg::*;
#(
  parameter int Q_in   = Q_IN,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [Q_in-1:0]   data_in,
  input  logic              data_in_valid,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [ADDR_W:0]   fill_level,
  output logic              overflow,
  input  logic              clear_overflow
);

  localparam int BPS = bytes_per_sample(Q_in);
  localparam int CNT_W = (BPS > 1) ? $clog2(BPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPS - 1);

  state_t            state_q, state_d;
  logic [Q_in-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              byte_valid_q, byte_valid_d;
  logic              pop_s;
  logic              xfer_s;
  logic              have_data_s;
  logic [Q_in-1:0]   fifo_data_s;

  sample_fifo_circular #(
    .WIDTH  (Q_in),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clock            (clock),
    .reset            (reset),
    .push_i           (data_in_valid),
    .data_i           (data_in),
    .pop_i            (pop_s),
    .data_o           (fifo_data_s),
    .fill_level_o     (fill_level),
    .overflow_o       (overflow),
    .clear_overflow_i (clear_overflow)
  );

  assign xfer_s      = (state_q == ST_SEND) && byte_ready;
  assign have_data_s = (fill_level != {(ADDR_W+1){1'b0}});

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (have_data_s) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: state_d = ST_SEND;
      ST_SEND: begin
        if (xfer_s && (cnt_q == LAST_CNT)) begin
          state_d = have_data_s ? ST_FETCH : ST_IDLE;
        end else begin
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next-state driven by the FSM.
  always_comb begin
    pop_s        = (state_q == ST_FETCH);
    byte_valid_d = (state_d == ST_SEND);
    if (pop_s) begin
      shift_d = fifo_data_s;
      cnt_d   = {CNT_W{1'b0}};
    end else if (xfer_s) begin
      shift_d = shift_q << 8;
      cnt_d   = cnt_q + 1'b1;
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q      <= {Q_in{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      byte_valid_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  assign byte_out   = shift_q[Q_in-1 -: 8];
  assign byte_valid = byte_valid_q;

endmodule
